// File: rtl/uart_pkg.sv
// Shared constants, state encoding and divider helper for the 8N1 UART.
package uart_pkg;

  localparam int OS_RATE   = 16;
  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_os_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OS_RATE) / 2) / (baud * OS_RATE);
  endfunction

endpackage

// File: rtl/uart_baud_os.sv
// Free-running oversample tick generator shared by the TX and RX paths.
module uart_baud_os #(
  parameter int OS_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  output logic os_tick
);

  if (OS_DIV < 2) begin : g_bad_div
    $error("uart_baud_os: OS_DIV must be at least 2");
  end

  localparam int CW = $clog2(OS_DIV);
  localparam logic [CW-1:0] LAST = CW'(OS_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign os_tick = (cnt == LAST);

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: shared 16x tick, independent TX and RX state machines.
//   state    | meaning
//   ST_IDLE  | line idle, waiting for start request / falling edge
//   ST_START | start bit (RX: qualify at mid-bit)
//   ST_DATA  | 8 data bits, LSB first
//   ST_STOP  | stop bit (RX: also break wait after a framing error)
module uart_core import uart_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx_line,
  output logic       busy,
  output logic       done,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int OS_DIV = calc_os_div(CLK_HZ, BAUD);
  localparam logic [3:0] OS_LAST  = 4'(OS_RATE - 1);
  localparam logic [3:0] OS_MID   = 4'(OS_RATE / 2 - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic os_tick;

  uart_baud_os #(.OS_DIV(OS_DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .os_tick (os_tick)
  );

  uart_state_e tx_state;
  logic [3:0]  tx_os;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (tx_state)
        ST_IDLE: begin
          if (start) begin
            tx_shift <= data_in;
            busy     <= 1'b1;
            tx_line  <= 1'b0;
            tx_os    <= '0;
            tx_state <= ST_START;
          end
        end
        default: begin
          if (os_tick) begin
            tx_os <= tx_os + 4'd1;
            if (tx_os == OS_LAST) begin
              case (tx_state)
                ST_START: begin
                  tx_line  <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_bit   <= '0;
                  tx_state <= ST_DATA;
                end
                ST_DATA: begin
                  if (tx_bit == BIT_LAST) begin
                    tx_line  <= 1'b1;
                    tx_state <= ST_STOP;
                  end else begin
                    tx_line  <= tx_shift[0];
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                  end
                end
                default: begin
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  tx_state <= ST_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  uart_state_e rx_state;
  logic        rx_s1, rx_s2;
  logic [3:0]  rx_os;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_brk;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_state  <= ST_IDLE;
      rx_os     <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_brk    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= rx_line;
      rx_s2     <= rx_s1;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        ST_IDLE: begin
          if (!rx_s2) begin
            rx_os    <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (os_tick) begin
            rx_os <= rx_os + 4'd1;
            if (rx_os == OS_MID) begin
              if (!rx_s2) begin
                rx_os    <= '0;
                rx_bit   <= '0;
                rx_state <= ST_DATA;
              end else begin
                rx_state <= ST_IDLE;
              end
            end
          end
        end
        ST_DATA: begin
          if (os_tick) begin
            rx_os <= rx_os + 4'd1;
            if (rx_os == OS_LAST) begin
              rx_shift <= {rx_s2, rx_shift[7:1]};
              rx_bit   <= rx_bit + 3'd1;
              if (rx_bit == BIT_LAST) rx_state <= ST_STOP;
            end
          end
        end
        default: begin
          // After a framing error hold here until the line releases (break).
          if (rx_brk) begin
            if (rx_s2) begin
              rx_brk   <= 1'b0;
              rx_state <= ST_IDLE;
            end
          end else if (os_tick) begin
            rx_os <= rx_os + 4'd1;
            if (rx_os == OS_LAST) begin
              if (rx_s2) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
                rx_state <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                rx_brk    <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: tick-count reference model plus directed/random frames.
module tb_uart_core;

  localparam int OSD  = 27;
  localparam int OSR  = 16;
  localparam int BITC = OSD * OSR;
  localparam int FRAME_TICKS = 10 * OSR;
  localparam int STOP_TICK   = OSR / 2 + 9 * OSR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = '0;
  logic       tx_line, busy, done;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err;
  logic       loop_en = 1'b0;
  logic       drv_rx = 1'b1;

  assign rx_line = loop_en ? tx_line : drv_rx;

  uart_core dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .tx_line   (tx_line),
    .busy      (busy),
    .done      (done),
    .rx_line   (rx_line),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle", name, act, exp);
    end
  endtask

  // Reference model: everything derives from the count of oversample ticks
  // since reset (one every OSD clocks) and the line history.
  int         cyc = 0;
  int         r0 = 0;
  bit         model_ok = 0;
  bit         e_tx = 1, e_busy = 0, e_done = 0, e_rx_valid = 0, e_frame_err = 0;
  logic [7:0] e_rx_data = '0;
  bit         tx_act = 0;
  int         tx_pa;
  logic [7:0] tx_byte;
  int         rx_mode = 0;
  int         rx_ps;
  logic [7:0] rx_acc;
  bit         sy1 = 1, sy2 = 1;

  function automatic int ticks_upto(input int p);
    return (p - r0 + 1) / OSD;
  endfunction

  always @(posedge clk) begin
    int p, n, b;
    bit seen, rxn;
    p = cyc;
    e_done = 0;
    e_rx_valid = 0;
    e_frame_err = 0;
    rxn = loop_en ? e_tx : drv_rx;
    if (rst) begin
      model_ok = 1;
      r0 = p + 1;
      tx_act = 0;
      e_tx = 1;
      e_busy = 0;
      e_rx_data = '0;
      rx_mode = 0;
      sy1 = 1;
      sy2 = 1;
    end else begin
      seen = sy2;
      sy2 = sy1;
      sy1 = rxn;
      if (!tx_act) begin
        e_tx = 1;
        e_busy = 0;
        if (start) begin
          tx_act = 1;
          tx_pa = p;
          tx_byte = data_in;
          e_tx = 0;
          e_busy = 1;
        end
      end else begin
        n = ticks_upto(p) - ticks_upto(tx_pa);
        if (n >= FRAME_TICKS) begin
          tx_act = 0;
          e_done = 1;
          e_busy = 0;
          e_tx = 1;
        end else begin
          e_busy = 1;
          b = n / OSR;
          if (b == 0)      e_tx = 0;
          else if (b <= 8) e_tx = tx_byte[b-1];
          else             e_tx = 1;
        end
      end
      case (rx_mode)
        0: if (!seen) begin rx_mode = 1; rx_ps = p; end
        1: if ((p - r0) % OSD == OSD - 1) begin
          n = ticks_upto(p) - ticks_upto(rx_ps);
          if (n == OSR / 2) begin
            if (seen) rx_mode = 0;
          end else if (n > OSR / 2 && n < STOP_TICK && (n - OSR / 2) % OSR == 0) begin
            rx_acc[(n - OSR / 2) / OSR - 1] = seen;
          end else if (n == STOP_TICK) begin
            if (seen) begin
              e_rx_data = rx_acc;
              e_rx_valid = 1;
              rx_mode = 0;
            end else begin
              e_frame_err = 1;
              rx_mode = 2;
            end
          end
        end
        default: if (seen) rx_mode = 0;
      endcase
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("tx_line", tx_line, e_tx);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("rx_valid", rx_valid, e_rx_valid);
      chk("frame_err", frame_err, e_frame_err);
      chk("rx_data", rx_data, e_rx_data);
    end
  end

  logic [7:0] rxq[$];
  int         ferr_cnt = 0;
  int         rxv_edge = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rxq.push_back(rx_data);
      rxv_edge = cyc - 1;
    end
    if (frame_err === 1'b1) ferr_cnt++;
  end

  int p_acc;

  task automatic send(input logic [7:0] d, input bit align);
    if (align)
      while ((cyc - r0) % OSD != OSD - 1) @(negedge clk);
    start = 1'b1;
    data_in = d;
    p_acc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int edge_idx);
    int k;
    k = 0;
    while (done !== 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done, 1'b1);
    edge_idx = cyc - 1;
  endtask

  task automatic drive_frame(input logic [7:0] d, input bit stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drv_rx = fr[i];
      repeat (BITC) @(negedge clk);
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int de, low;
    logic [7:0] d;
    logic [7:0] exp_b2b [4];
    exp_b2b = '{8'h00, 8'hFF, 8'h55, 8'hA5};

    repeat (10) @(negedge clk);
    chk("rst_tx_line", tx_line, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Loopback 0xB3, accept aligned to a tick so bit widths are exact.
    loop_en = 1'b1;
    send(8'hB3, 1);
    low = 0;
    while (tx_line === 1'b0 && low < 1000) begin
      low++;
      @(negedge clk);
    end
    chk("start_bit_len", low, BITC);
    wait_done(5000, de);
    chk("done_latency", de - p_acc, 10 * BITC);
    // Synchronizer delay is absorbed by the tick grid: stop sampled 152 ticks on.
    chk("rx_latency", rxv_edge - p_acc, STOP_TICK * OSD);
    @(negedge clk);
    chk("busy_after_done", busy, 1'b0);
    chk("b3_count", rxq.size(), 1);
    chk("b3_data", rx_data, 8'hB3);
    rxq.delete();

    // Back-to-back frames, each start on the cycle busy drops.
    for (int i = 0; i < 4; i++) begin
      send(exp_b2b[i], 0);
      wait_done(5000, de);
    end
    repeat (20) @(negedge clk);
    chk("b2b_count", rxq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b_byte%0d", i), (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD, 32'(exp_b2b[i]));
    chk("b2b_ferr", ferr_cnt, 0);
    rxq.delete();

    // Start while busy must be ignored.
    send(8'h5A, 1);
    repeat (1000) @(negedge clk);
    start = 1'b1;
    data_in = 8'h12;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000, de);
    chk("ignore_latency", de - p_acc, 10 * BITC);
    repeat (20) @(negedge clk);
    chk("ignore_count", rxq.size(), 1);
    chk("ignore_data", rx_data, 8'h5A);
    rxq.delete();

    // Short low glitch is rejected.
    loop_en = 1'b0;
    drv_rx = 1'b0;
    repeat (100) @(negedge clk);
    drv_rx = 1'b1;
    repeat (600) @(negedge clk);
    chk("glitch_rx", rxq.size(), 0);
    chk("glitch_ferr", ferr_cnt, 0);

    // Framing error with break, then recovery.
    drive_frame(8'h3C, 1'b0);
    repeat (2 * BITC) @(negedge clk);
    drv_rx = 1'b1;
    repeat (2 * BITC) @(negedge clk);
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_rx_count", rxq.size(), 0);
    chk("ferr_rx_data_kept", rx_data, 8'h5A);
    drive_frame(8'h3C, 1'b1);
    repeat (500) @(negedge clk);
    chk("recover_count", rxq.size(), 1);
    chk("recover_data", rx_data, 8'h3C);
    rxq.delete();

    // Reset in the middle of a transmitted frame.
    loop_en = 1'b1;
    send(8'hC6, 0);
    repeat (4 * BITC + 100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_line", tx_line, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    rxq.delete();
    repeat (50) @(negedge clk);
    send(8'h81, 0);
    wait_done(5000, de);
    repeat (20) @(negedge clk);
    chk("midrst_count", rxq.size(), 1);
    chk("midrst_data", rx_data, 8'h81);
    rxq.delete();

    // Random bytes, random phase, random ignored starts mid-frame.
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 300)) @(negedge clk);
      send(d, 0);
      repeat ($urandom_range(10, 3000)) @(negedge clk);
      start = 1'b1;
      data_in = 8'($urandom_range(0, 255));
      @(negedge clk);
      start = 1'b0;
      wait_done(5000, de);
      repeat (5) @(negedge clk);
      chk("rand_count", rxq.size(), 1);
      chk("rand_data", rx_data, d);
      rxq.delete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
Full-duplex 8N1 UART: a shared 16x-oversample baud generator, a transmitter and a receiver in one block, on a single clock domain. Sits between a byte-wide parallel interface (start/data_in out, rx_data/rx_valid in) and the serial pins. A loopback of tx_line to rx_line must return every transmitted byte.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz.
BAUD, 115200, serial bit rate.
OS_DIV, derived: round(CLK_HZ/(BAUD*16)), clocks per oversample tick. Default value is 27; 432 clocks per bit. Must be >= 2; elaboration error otherwise.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle transmit request; sampled only while busy=0.
data_in  in  8  byte to send; latched on the cycle start is accepted.
tx_line  out  1  serial output, idle high.
busy  out  1  high from the cycle after start is accepted until end of stop bit.
done  out  1  one-cycle pulse at end of stop bit.
rx_line  in  1  serial input, asynchronous to clk.
rx_data  out  8  last correctly framed received byte.
rx_valid  out  1  one-cycle pulse when rx_data updates.
frame_err  out  1  one-cycle pulse when a stop bit is sampled low.

Behaviour:
- All registers reset synchronously. Reset values: tx_line=1, busy=0, done=0, rx_data=0, rx_valid=0, frame_err=0; all FSMs go to IDLE; all counters reset to 0. Reset mid-frame aborts the frame, and tx_line returns high on the next edge.
- Baud gen: free-running counter 0..OS_DIV-1; os_tick pulses one cycle when the counter wraps. Always enabled.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: on start=1, latch data_in, set busy=1, enter START with tx_line=0, and clear the 4-bit oversample counter. The first bit is therefore a full bit.
  - Each bit lasts 16 os_ticks.
  - DATA sends bits 0..7, LSB first.
  - STOP drives 1. After its 16th tick: done=1 for one cycle, busy=0 in that same cycle, return to IDLE.
  - start while busy is ignored.
  - A new start is accepted on the first cycle busy=0, giving back-to-back frames with no extra idle bit.
- RX input: 2-flop synchronizer on rx_line, both flops reset to 1.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: synchronized line=0 enters START and clears the oversample counter.
  - START: at the 8th os_tick (mid-bit), a low line enters DATA. A high line returns to IDLE (glitch rejection).
  - DATA: sample every 16 os_ticks, shifting LSB first; 8 samples.
  - STOP: sample after 16 os_ticks.
    - High: rx_data<=shift register and rx_valid=1 for one cycle (same cycle), go to IDLE.
    - Low: frame_err=1 for one cycle, rx_data unchanged; wait for line high before IDLE (break handling).
- Latency: rx_valid asserts about 9.5 bit times plus 2 clocks after the start-bit falling edge, i.e. before the transmitter's done in loopback.
- TX and RX are fully independent and can be active simultaneously.

Decomposition:
- Package uart_pkg: OS_RATE=16, DATA_BITS=8, a tx/rx state enum (IDLE, START, DATA, STOP), and a function computing OS_DIV.
- Sub-module uart_baud_os (os_tick generator) instantiated once and shared.
- TX and RX FSMs as two always-blocks in uart_core.

Test Plan:
- Reset: hold rst 10 cycles -> tx_line=1, busy=0, done=0, rx_data=0x00, rx_valid=0, frame_err=0.
- Loopback 0xB3: wire tx_line to rx_line and pulse start with data_in=0xB3.
  - tx_line is low for exactly 432 clocks, then sends 1,1,0,0,1,1,0,1.
  - rx_valid pulses once with rx_data=0xB3.
  - done pulses once about 4320 clocks after accept, then busy=0.
- Back-to-back 0x00, 0xFF, 0x55, 0xA5: each start is issued the cycle busy falls -> four rx_valid pulses in order with matching data and no frame_err.
- start asserted while busy with 0x12 -> ignored; only the original byte is received, and busy timing is unchanged.
- rx_line low pulse of 100 clocks -> no rx_valid, no frame_err; RX returns to IDLE.
- Drive a frame 0x3C with stop bit=0 -> frame_err pulses, rx_valid stays 0, rx_data keeps its prior value.
- Assert rst mid-frame (after 3 data bits) -> tx_line=1 next cycle, busy=0; the next full frame is received correctly.
